ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the MIPS single-cycle datapath. It holds the program counter and fetches one instruction at a time from instruction memory over a request/valid handshake. It presents the instruction to the decoder/controller for one commit cycle. It then computes the next PC from the controller's `npc_op` (+4, branch, jump) and the held instruction's immediate fields.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: PC loaded on reset.
- `IM_WORDS`, default 1024: instruction memory depth in words. Used only by the range check.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `im_req`  out  1: fetch request, registered.
- `im_addr`  out  32: byte address of the fetch; equals `pc`.
- `im_rvalid`  in  1: memory returns `im_rdata`. Meaningful only while `im_req`=1.
- `im_rdata`  in  32: fetched instruction word.
- `instr`  out  32: held instruction, registered.
- `pc`  out  32: address of `instr`.
- `pc_plus4`  out  32: `pc`+4 mod 2^32, combinational. Feeds the jal write-data path.
- `instr_valid`  out  1: one-cycle commit strobe. Register file and data memory writes are enabled only when it is 1.
- `npc_op`  in  2: 00 = +4, 01 = branch taken, 10 = jump, 11 = treated as +4. Sampled only when `instr_valid`=1.
- `fault`  out  1: range fault flag, sticky until reset.

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- Reset values: state IDLE, `pc`=`RESET_PC`, `instr`=0, `im_req`=0, `instr_valid`=0, `fault`=0.
- IDLE: always goes to FETCH on the next cycle; `im_req` becomes 1.
- FETCH: `im_req`=1 and `im_addr`=`pc`, both held stable until `im_rvalid`=1.
  - When `im_rvalid`=1: `instr`<=`im_rdata`, `im_req`<=0, go to EXEC.
- EXEC: `instr_valid`=1 for exactly this cycle. At the cycle end, `pc`<=next PC and the block returns to FETCH with `im_req`<=1.
- Next PC:
  - +4: `pc_plus4`.
  - Branch: `pc_plus4` + {{14{instr[15]}}, instr[15:0], 2'b00}, mod 2^32.
  - Jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
- HALT: reached only via a range fault. No requests issued; `instr_valid`=0. Left only by `rst`.
- `im_rvalid` outside FETCH is ignored.
- `npc_op` outside EXEC is ignored.

## Timing
- Fetch latency: if `im_rvalid` is sampled high at edge t, `instr_valid`=1 during cycle t+1 and the new `im_req`/`im_addr` appear in cycle t+2.
- Throughput: at least 2 cycles per instruction. First request appears 1 cycle after `rst` deasserts.
- Memory with zero wait states (`im_rvalid`=1 in the first FETCH cycle) gives the minimum: 2 cycles per instruction.
- `rst` asserted in any state, including mid-FETCH: takes effect at the next edge. The outstanding request is abandoned, and a late `im_rvalid` is ignored because the state is IDLE.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0. Branch offsets wrap likewise.
- `pc` changes only at the end of EXEC, so `pc` and `pc_plus4` are stable throughout the commit cycle.

## Configuration
- `IFU_RANGE_CHECK_EN` defined: at the end of EXEC, a next PC with word index (next_pc - `RESET_PC`) >> 2 at or above `IM_WORDS` is treated as a range fault. The subtraction is unsigned, so PCs below `RESET_PC` also fault. On a fault:
  - `pc` is loaded with the offending value (for debug).
  - `fault`<=1 and the state goes to HALT.
- Not defined: no check. `fault` is tied to 0 and HALT is unreachable.

## Test plan
- Reset then run: hold `rst` 3 cycles, release. Expect `im_req`=1 and `im_addr`=32'h3000 in the next cycle, and `instr_valid`=0 throughout reset.
- Sequential fetch with latency 1 and 3: return 32'h2008_0001 at 0x3000 and any word at 0x3004, `npc_op`=00. Expect `instr_valid` pulses of exactly 1 cycle and `im_addr` 0x3000 → 0x3004 → 0x3008. `im_addr` stays stable while `im_rvalid`=0.
- Branch: at `pc`=0x3008, `instr`=32'h1000_FFFF, `npc_op`=01. Expect next `pc`=0x3008. With `instr`=32'h1000_0002, expect 0x3014.
- Jump and wrap: at 0x3000, `instr`=32'h0800_0C03, `npc_op`=10, expect 0x300C. Force `pc`=32'hFFFF_FFFC with `npc_op`=00, expect 0. `npc_op`=11 behaves as +4.
- Reset mid-fetch: assert `rst` during FETCH while `im_rvalid`=0, then pulse `im_rvalid` one cycle later. Expect `instr` still 0, no `instr_valid`, and a restart at 0x3000.
- `IFU_RANGE_CHECK_EN` with `IM_WORDS`=4: run 4 sequential instructions. Expect `fault`=1 and `pc`=0x3010 after the 4th commit, then no further `im_req` until `rst`.

Source files
------------

// File: rtl/ifu.sv
// ----------------------------------------------------------------------------
// ifu -- instruction fetch unit for the MIPS single-cycle datapath.
//
// Holds the PC, fetches one instruction per request/valid handshake, presents
// it to the decoder for a single commit cycle (o_instr_valid), then advances
// the PC according to i_npc_op (+4, branch, jump).
//
// Parameters:
//   RESET_PC  PC loaded on reset.
//   IM_WORDS  instruction memory depth in words (range check only).
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   o_im_req, o_im_addr fetch request (registered) and byte address (= PC)
//   i_im_rvalid/rdata   fetch response, honoured only while fetching
//   o_instr, o_pc       held instruction and its address
//   o_pc_plus4          PC + 4 (jal write data)
//   o_instr_valid       one-cycle commit strobe
//   i_npc_op            00 +4, 01 branch, 10 jump, 11 +4 (sampled on commit)
//   o_fault             sticky range fault
//
// Build option: define IFU_RANGE_CHECK_EN to enable the next-PC range check;
// a failing next PC is loaded into the PC, o_fault sets and the unit halts.
// Without it o_fault stays 0 and HALT is never entered.
// ----------------------------------------------------------------------------
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_im_req,
    output logic [31:0] o_im_addr,
    input  logic        i_im_rvalid,
    input  logic [31:0] i_im_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_instr_valid,
    input  logic [1:0]  i_npc_op,
    output logic        o_fault
);

`ifdef IFU_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    localparam logic [31:0] IM_WORDS_U = 32'(IM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_instr;
    logic        r_im_req, r_fault;

    logic [31:0] w_pc_plus4, w_br_off, w_npc, w_pc_off;
    logic        w_range_fault;
    logic        w_capture, w_commit;

    // ---------------- next-PC datapath ----------------
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    always_comb begin
        w_npc = w_pc_plus4;
        case (i_npc_op)
            2'b01:   w_npc = w_pc_plus4 + w_br_off;
            2'b10:   w_npc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
            default: w_npc = w_pc_plus4;
        endcase
    end

    // Unsigned offset: PCs below RESET_PC wrap to huge values and fault too.
    assign w_pc_off      = w_npc - RESET_PC;
    assign w_range_fault = RANGE_EN && ({2'b00, w_pc_off[31:2]} >= IM_WORDS_U);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: if (i_im_rvalid) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = w_range_fault ? S_HALT : S_FETCH;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / enables ----------------
    always_comb begin
        w_capture     = 1'b0;
        w_commit      = 1'b0;
        o_instr_valid = 1'b0;
        case (r_state)
            S_FETCH: w_capture = i_im_rvalid;
            S_EXEC: begin
                w_commit      = 1'b1;
                o_instr_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- registered datapath ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc     <= RESET_PC;
            r_instr  <= 32'd0;
            r_im_req <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            if (r_state == S_IDLE) r_im_req <= 1'b1;
            if (w_capture) begin
                r_instr  <= i_im_rdata;
                r_im_req <= 1'b0;
            end
            if (w_commit) begin
                // Offending PC is kept on a fault so it can be inspected.
                r_pc <= w_npc;
                if (w_range_fault) r_fault  <= 1'b1;
                else               r_im_req <= 1'b1;
            end
        end
    end

    assign o_im_req   = r_im_req;
    assign o_im_addr  = r_pc;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = w_pc_plus4;
    assign o_instr    = r_instr;
    assign o_fault    = r_fault;

endmodule

// File: tb/tb_ifu.sv
// ----------------------------------------------------------------------------
// tb_ifu -- bench for ifu. Three instances share the same stimulus:
//   0: defaults (RESET_PC 0x3000, 1024 words)
//   1: RESET_PC 0xFFFF_FFFC (PC wrap)
//   2: RESET_PC 0x3000, IM_WORDS 4 (range fault when enabled)
// A transaction-level model tracks each instance; outputs are compared on
// every falling edge, plus literal spot checks from the main sequence.
// ----------------------------------------------------------------------------
module tb_ifu;

`ifdef IFU_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int N = 3;
    localparam logic [31:0] RPC [N] = '{32'h0000_3000, 32'hFFFF_FFFC, 32'h0000_3000};
    localparam int          WRD [N] = '{1024, 1024, 4};

    logic        clk = 1'b0;
    logic        rst, rvalid;
    logic [31:0] rdata;
    logic [1:0]  op;

    logic        d_req [N];
    logic [31:0] d_addr[N];
    logic [31:0] d_ins [N];
    logic [31:0] d_pc  [N];
    logic [31:0] d_p4  [N];
    logic        d_iv  [N];
    logic        d_flt [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifu #(.RESET_PC(32'h0000_3000), .IM_WORDS(1024)) u_a (
        .i_clk(clk), .i_rst(rst), .o_im_req(d_req[0]), .o_im_addr(d_addr[0]),
        .i_im_rvalid(rvalid), .i_im_rdata(rdata), .o_instr(d_ins[0]), .o_pc(d_pc[0]),
        .o_pc_plus4(d_p4[0]), .o_instr_valid(d_iv[0]), .i_npc_op(op), .o_fault(d_flt[0]));
    ifu #(.RESET_PC(32'hFFFF_FFFC), .IM_WORDS(1024)) u_w (
        .i_clk(clk), .i_rst(rst), .o_im_req(d_req[1]), .o_im_addr(d_addr[1]),
        .i_im_rvalid(rvalid), .i_im_rdata(rdata), .o_instr(d_ins[1]), .o_pc(d_pc[1]),
        .o_pc_plus4(d_p4[1]), .o_instr_valid(d_iv[1]), .i_npc_op(op), .o_fault(d_flt[1]));
    ifu #(.RESET_PC(32'h0000_3000), .IM_WORDS(4)) u_r (
        .i_clk(clk), .i_rst(rst), .o_im_req(d_req[2]), .o_im_addr(d_addr[2]),
        .i_im_rvalid(rvalid), .i_im_rdata(rdata), .o_instr(d_ins[2]), .o_pc(d_pc[2]),
        .o_pc_plus4(d_p4[2]), .o_instr_valid(d_iv[2]), .i_npc_op(op), .o_fault(d_flt[2]));

    // ---------------- model ----------------
    logic        m_req [N];
    logic [31:0] m_pc  [N];
    logic [31:0] m_ins [N];
    logic        m_iv  [N];
    logic        m_flt [N];

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] ins,
                                            input logic [1:0] o);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        off = int'($signed(ins[15:0])) * 4;
        if (o == 2'b01)      return seq + 32'(off);
        else if (o == 2'b10) return (seq & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
        else                 return seq;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                m_req[k] = 1'b0; m_pc[k] = RPC[k]; m_ins[k] = 32'd0;
                m_iv[k] = 1'b0;  m_flt[k] = 1'b0;
            end else if (m_flt[k]) begin
                // halted: nothing changes until reset
            end else if (m_iv[k]) begin
                logic [31:0] np;
                np = next_pc(m_pc[k], m_ins[k], op);
                m_pc[k] = np;
                m_iv[k] = 1'b0;
                if (CHK && ((np - RPC[k]) / 32'd4) >= 32'(WRD[k])) m_flt[k] = 1'b1;
                else m_req[k] = 1'b1;
            end else if (m_req[k]) begin
                if (rvalid) begin
                    m_ins[k] = rdata; m_req[k] = 1'b0; m_iv[k] = 1'b1;
                end
            end else begin
                m_req[k] = 1'b1;   // first cycle out of reset
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst !== 1'bx) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("req%0d", k),   32'(d_req[k]), 32'(m_req[k]));
                chk($sformatf("addr%0d", k),  d_addr[k], m_pc[k]);
                chk($sformatf("pc%0d", k),    d_pc[k],   m_pc[k]);
                chk($sformatf("p4_%0d", k),   d_p4[k],   m_pc[k] + 32'd4);
                chk($sformatf("instr%0d", k), d_ins[k],  m_ins[k]);
                chk($sformatf("iv%0d", k),    32'(d_iv[k]),  32'(m_iv[k]));
                chk($sformatf("fault%0d", k), 32'(d_flt[k]), 32'(m_flt[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Entered on a falling edge; waits for the request, answers after lat
    // cycles, then supplies npc_op in the commit cycle. Returns on the falling
    // edge after the commit edge.
    task automatic fetch(input int lat, input logic [31:0] d, input logic [1:0] o);
        int n = 0;
        while (!m_req[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) chk("fetch_timeout", 32'(m_req[0]), 32'd1);
        op = 2'b10;                        // ignored outside commit
        for (int i = 1; i < lat; i++) begin
            rvalid = 1'b0; rdata = $urandom;
            @(negedge clk);
        end
        rvalid = 1'b1; rdata = d;
        @(negedge clk);
        rvalid = 1'b1; rdata = $urandom;   // ignored outside fetch
        op = o;
        @(negedge clk);
        rvalid = 1'b0;
        op = 2'b10;
    endtask

    task automatic do_reset();
        rst = 1'b1; rvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rvalid = 1'b0; rdata = 32'd0; op = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_iv", 32'(d_iv[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("lit_req0",  32'(d_req[0]), 32'd1);
        chk("lit_addr0", d_addr[0], 32'h0000_3000);

        // sequential: latency 1, 3, 1, 1
        fetch(1, 32'h2008_0001, 2'b00);
        chk("lit_seq1", d_pc[0], 32'h0000_3004);
        chk("lit_wrap", d_pc[1], 32'h0000_0000);
        chk("lit_ins0", d_ins[0], 32'h2008_0001);
        fetch(3, 32'h1234_5678, 2'b00);
        chk("lit_seq2", d_pc[0], 32'h0000_3008);
        fetch(1, 32'h0000_0000, 2'b00);
        fetch(1, 32'h0000_0000, 2'b11);
        chk("lit_seq4", d_pc[2], 32'h0000_3010);
        repeat (3) @(negedge clk);
`ifdef IFU_RANGE_CHECK_EN
        chk("lit_fault", 32'(d_flt[2]), 32'd1);
        chk("lit_halt_req", 32'(d_req[2]), 32'd0);
`endif

        // branches
        do_reset();
        fetch(1, 32'h0000_0000, 2'b00);
        fetch(2, 32'h0000_0000, 2'b00);
        fetch(1, 32'h1000_FFFF, 2'b01);
        chk("lit_br_back", d_pc[0], 32'h0000_3008);
        fetch(1, 32'h1000_0002, 2'b01);
        chk("lit_br_fwd", d_pc[0], 32'h0000_3014);

        // jump, then op 11 as +4
        do_reset();
        fetch(1, 32'h0800_0C03, 2'b10);
        chk("lit_jump", d_pc[0], 32'h0000_300C);
        fetch(2, 32'h0800_0C03, 2'b11);
        chk("lit_op11", d_pc[0], 32'h0000_3010);

        // reset mid-fetch with a late response
        chk("lit_infetch", 32'(d_req[0]), 32'd1);
        rst = 1'b1; rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rvalid = 1'b0;
        chk("lit_mf_instr", d_ins[0], 32'd0);
        chk("lit_mf_iv",    32'(d_iv[0]), 32'd0);
        chk("lit_mf_addr",  d_addr[0], 32'h0000_3000);
        fetch(1, 32'h0000_0000, 2'b00);
        chk("lit_mf_next", d_pc[0], 32'h0000_3004);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
